// File: rtl/memory_read_responder_if.sv
// ---------------------------------------------------------------------------
// memory_read_responder_if
//
// Purpose:
//     Request/response bundle between a requester and the
//     memory_read_responder. clk and rst are not part of the bundle. They
//     stay plain ports on the responder.
//
// Signals:
//     enable     requester -> responder  request strobe, one request per cycle
//     wr         requester -> responder  1 = write, 0 = read (when enable=1)
//     addr       requester -> responder  byte address of the request
//     data_in    requester -> responder  write data
//     data_out   responder -> requester  returned read data (0 when idle)
//     data_valid responder -> requester  one-cycle pulse per returned read
//     pending    responder -> requester  accepted reads not yet returned
//
// Modports:
//     master  the requester side
//     slave   the responder side
// ---------------------------------------------------------------------------
interface memory_read_responder_if;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  pending;

    modport master (
        output enable,
        output wr,
        output addr,
        output data_in,
        input  data_out,
        input  data_valid,
        input  pending
    );

    modport slave (
        input  enable,
        input  wr,
        input  addr,
        input  data_in,
        output data_out,
        output data_valid,
        output pending
    );
endinterface

// File: rtl/memory_read_responder.sv
// ---------------------------------------------------------------------------
// memory_read_responder
//
// Purpose:
//     Word-addressed 16-bit memory that behaves as a fixed-latency read
//     responder. It accepts one request per cycle with no back-pressure.
//     A write lands at the end of its cycle. A read samples the word as it
//     stands at the start of its cycle and comes back exactly LATENCY cycles
//     later, with data_valid pulsed for one cycle. Reads are fully
//     pipelined and return in order.
//
// Parameters:
//     LATENCY     cycles from read request to data return (1..8)
//     DEPTH_LOG2  log2 of the number of 16-bit words stored
//
// Ports:
//     clk   single clock. All state changes on its rising edge.
//     rst   synchronous active-high reset. It clears the read pipeline and
//           the pending count. Storage is left untouched.
//     bus   slave side of memory_read_responder_if
//           (enable, wr, addr, data_in -> data_out, data_valid, pending)
// ---------------------------------------------------------------------------
module memory_read_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    memory_read_responder_if.slave  bus
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [15:0]           r_mem [WORDS];

    // Pipeline stage i holds the read captured i+1 edges ago. The last
    // stage drives the outputs directly, so the outputs are registered.
    logic [LATENCY-1:0]    r_vld;
    logic [15:0]           r_dat [LATENCY];
    logic [3:0]            r_pending;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ret;
    logic                  w_unused;

    // addr[0] selects a byte within the word. Bits above DEPTH_LOG2 alias.
    assign w_idx    = bus.addr[DEPTH_LOG2:1];
    assign w_unused = ^bus.addr;

    // Requests that arrive during reset are dropped.
    assign w_rd_acc = bus.enable & ~bus.wr & ~rst;
    assign w_wr_acc = bus.enable &  bus.wr & ~rst;
    assign w_ret    = r_vld[LATENCY-1];

    // Storage has no reset, so its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_idx] <= bus.data_in;
        end
    end

    // A read captures r_mem before any write from a later cycle can land.
    // Only one request is taken per cycle, so a read never collides with a
    // write in the same cycle. Data is zeroed for bubbles, which keeps
    // data_out at 0 whenever data_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld     <= '0;
            r_pending <= 4'd0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dat[i] <= 16'h0000;
            end
        end else begin
            r_vld[0] <= w_rd_acc;
            r_dat[0] <= w_rd_acc ? r_mem[w_idx] : 16'h0000;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
            case ({w_rd_acc, w_ret})
                2'b10:   r_pending <= r_pending + 4'd1;
                2'b01:   r_pending <= r_pending - 4'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    assign bus.data_valid = r_vld[LATENCY-1];
    assign bus.data_out   = r_dat[LATENCY-1];
    assign bus.pending    = r_pending;

endmodule

// File: tb/tb_memory_read_responder.sv
module tb_memory_read_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    = 1'b1;
    logic        t_en   = 1'b0;
    logic        t_wr   = 1'b0;
    logic [15:0] t_addr = 16'h0000;
    logic [15:0] t_din  = 16'h0000;
    logic        sel_l1 = 1'b0;

    memory_read_responder_if if4 ();
    memory_read_responder_if if1 ();

    assign if4.enable  = t_en & ~sel_l1;
    assign if4.wr      = t_wr;
    assign if4.addr    = t_addr;
    assign if4.data_in = t_din;
    assign if1.enable  = t_en & sel_l1;
    assign if1.wr      = t_wr;
    assign if1.addr    = t_addr;
    assign if1.data_in = t_din;

    memory_read_responder #(.LATENCY(4), .DEPTH_LOG2(10)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    memory_read_responder #(.LATENCY(1), .DEPTH_LOG2(10)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    logic        dv;
    logic [15:0] dout;
    logic [3:0]  pend;
    int          lat;
    assign dv   = sel_l1 ? if1.data_valid : if4.data_valid;
    assign dout = sel_l1 ? if1.data_out   : if4.data_out;
    assign pend = sel_l1 ? if1.pending    : if4.pending;
    always_comb lat = sel_l1 ? 1 : 4;

    int n_checks = 0;
    int n_fail   = 0;

    // One call = one cycle. Inputs are set at the negedge, and the outputs
    // seen right after the call belong to that same cycle.
    task automatic cyc(input logic r, input logic en, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        rst    = r;
        t_en   = en;
        t_wr   = w;
        t_addr = a;
        t_din  = d;
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, 1'b1, 16'h0100, 16'hDEAD);
        cyc(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 16'h0100, 16'h5555);
        n_checks++;
        if (if4.data_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_dv4 got %b expected 0", if4.data_valid);
        end
        n_checks++;
        if (if4.data_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_dout4 got %h expected 0000", if4.data_out);
        end
        n_checks++;
        if (if4.pending !== 4'd0) begin
            n_fail++; $display("FAIL reset_pend4 got %0d expected 0", if4.pending);
        end
        n_checks++;
        if (if1.data_valid !== 1'b0 || if1.data_out !== 16'h0000 || if1.pending !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_l1 got dv=%b dout=%h pend=%0d expected 0/0000/0",
                     if1.data_valid, if1.data_out, if1.pending);
        end
        // Write and read presented during reset must both be dropped.
        cyc(1'b1, 1'b1, 1'b1, 16'h0100, 16'hDEAD);
        cyc(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
        n_checks++;
        if (pend !== 4'd0) begin
            n_fail++; $display("FAIL reset_read_ignored pend got %0d expected 0", pend);
        end
        for (int k = 1; k <= 5; k++) begin
            logic        ev;
            logic [15:0] ed;
            logic [3:0]  ep;
            cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            ev = (k == 4);
            ed = ev ? 16'h5555 : 16'h0000;
            ep = (k <= 4) ? 4'd1 : 4'd0;
            n_checks++;
            if (dv !== ev || dout !== ed || pend !== ep) begin
                n_fail++;
                $display("FAIL reset_readback k=%0d got dv=%b dout=%h pend=%0d expected %b/%h/%0d",
                         k, dv, dout, pend, ev, ed, ep);
            end
        end
    endtask

    task automatic test_line_fill();
        int peak;
        peak = 0;
        for (int k = 0; k <= 17 + lat; k++) begin
            int          acc;
            int          ret;
            logic        ev;
            logic [15:0] ed;
            if (k < 8)
                cyc(1'b0, 1'b1, 1'b1, 16'h1230 + 16'(2*k), 16'hA000 + 16'(k));
            else if (k < 16)
                cyc(1'b0, 1'b1, 1'b0, 16'h1230 + 16'(2*(k-8)), 16'h0000);
            else
                cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            acc = k - 8;       if (acc < 0) acc = 0; if (acc > 8) acc = 8;
            ret = k - 8 - lat; if (ret < 0) ret = 0; if (ret > 8) ret = 8;
            ev = (k >= 8 + lat) && (k < 16 + lat);
            ed = ev ? 16'hA000 + 16'(k - 8 - lat) : 16'h0000;
            n_checks++;
            if (dv !== ev || dout !== ed) begin
                n_fail++;
                $display("FAIL line_fill L=%0d k=%0d got dv=%b dout=%h expected %b/%h",
                         lat, k, dv, dout, ev, ed);
            end
            n_checks++;
            if (pend !== 4'(acc - ret)) begin
                n_fail++;
                $display("FAIL line_fill_pend L=%0d k=%0d got %0d expected %0d",
                         lat, k, pend, acc - ret);
            end
            if (int'(pend) > peak) peak = int'(pend);
        end
        n_checks++;
        if (peak != lat) begin
            n_fail++; $display("FAIL line_fill_peak got %0d expected %0d", peak, lat);
        end
    endtask

    task automatic test_write_hazard();
        for (int k = 0; k <= 8; k++) begin
            logic        ev;
            logic [15:0] ed;
            case (k)
                0:       cyc(1'b0, 1'b1, 1'b1, 16'h0040, 16'h1111);
                1:       cyc(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
                2:       cyc(1'b0, 1'b1, 1'b1, 16'h0040, 16'h2222);
                3:       cyc(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
                default: cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            endcase
            ev = (k == 5) || (k == 7);
            ed = (k == 5) ? 16'h1111 : (k == 7) ? 16'h2222 : 16'h0000;
            n_checks++;
            if (dv !== ev || dout !== ed) begin
                n_fail++;
                $display("FAIL write_hazard k=%0d got dv=%b dout=%h expected %b/%h",
                         k, dv, dout, ev, ed);
            end
        end
    endtask

    task automatic test_bubbles();
        for (int k = 0; k <= 8; k++) begin
            logic        ev;
            logic [15:0] ed;
            case (k)
                0:       cyc(1'b0, 1'b1, 1'b0, 16'h1230, 16'h0000);
                2:       cyc(1'b0, 1'b1, 1'b0, 16'h1232, 16'h0000);
                3:       cyc(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000);
                default: cyc(1'b0, 1'b0, 1'b1, 16'h1236, 16'hFFFF);
            endcase
            ev = (k == 4) || (k == 6) || (k == 7);
            ed = (k == 4) ? 16'hA000 : (k == 6) ? 16'hA001 : (k == 7) ? 16'hA002 : 16'h0000;
            n_checks++;
            if (dv !== ev || dout !== ed) begin
                n_fail++;
                $display("FAIL bubbles k=%0d got dv=%b dout=%h expected %b/%h",
                         k, dv, dout, ev, ed);
            end
            if (k == 8) begin
                n_checks++;
                if (pend !== 4'd0) begin
                    n_fail++; $display("FAIL bubbles_pend got %0d expected 0", pend);
                end
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        for (int k = 0; k <= 15; k++) begin
            case (k)
                0:       cyc(1'b0, 1'b1, 1'b0, 16'h1230, 16'h0000);
                1:       cyc(1'b0, 1'b1, 1'b0, 16'h1232, 16'h0000);
                2:       cyc(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000);
                3:       cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
                10:      cyc(1'b0, 1'b1, 1'b0, 16'h1236, 16'h0000);
                default: cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            endcase
            if (k == 3) begin
                n_checks++;
                if (pend !== 4'd3) begin
                    n_fail++; $display("FAIL mid_fill_pend_before got %0d expected 3", pend);
                end
            end
            if (k >= 4 && k <= 9) begin
                n_checks++;
                if (dv !== 1'b0 || pend !== 4'd0) begin
                    n_fail++;
                    $display("FAIL mid_fill_flushed k=%0d got dv=%b pend=%0d expected 0/0",
                             k, dv, pend);
                end
            end
            if (k == 14) begin
                n_checks++;
                if (dv !== 1'b1 || dout !== 16'hA003) begin
                    n_fail++;
                    $display("FAIL mid_fill_readback got dv=%b dout=%h expected 1/a003", dv, dout);
                end
            end
        end
    endtask

    task automatic test_alias();
        for (int k = 0; k <= 9; k++) begin
            logic        ev;
            logic [15:0] ed;
            case (k)
                0:       cyc(1'b0, 1'b1, 1'b1, 16'h0003, 16'hBEEF);
                1:       cyc(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000);
                2:       cyc(1'b0, 1'b1, 1'b0, 16'h0802, 16'h0000);
                3:       cyc(1'b0, 1'b0, 1'b1, 16'h0002, 16'h0BAD);
                4:       cyc(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000);
                default: cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            endcase
            ev = (k == 5) || (k == 6) || (k == 8);
            ed = ev ? 16'hBEEF : 16'h0000;
            n_checks++;
            if (dv !== ev || dout !== ed) begin
                n_fail++;
                $display("FAIL alias k=%0d got dv=%b dout=%h expected %b/%h",
                         k, dv, dout, ev, ed);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line_fill();
        test_write_hazard();
        test_bubbles();
        test_reset_mid_fill();
        test_alias();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        sel_l1 = 1'b1;
        test_line_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_read_responder.md
MEMORY_READ_RESPONDER -- requirements
Module: memory_read_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning the fixed number of cycles from read request to data return; legal range 1..8.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 16-bit words stored.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port enable, input, 1, request strobe; one request per cycle when high.
REQ-006 SHALL have port wr, input, 1, request type when enable is high: 1 = write, 0 = read.
REQ-007 SHALL have port addr, input, 16, byte address of the request.
REQ-008 SHALL have port data_in, input, 16, write data.
REQ-009 SHALL have port data_out, output, 16, read data returned.
REQ-010 SHALL have port data_valid, output, 1, high for exactly one cycle per returned read.
REQ-011 SHALL have port pending, output, 4, count of accepted reads not yet returned.

Function
REQ-012 SHALL use word index addr[DEPTH_LOG2:1] for storage; addr[0] is ignored, and bits above DEPTH_LOG2 are ignored, so those addresses alias.
REQ-013 SHALL accept every request; there is no back-pressure and no ready signal.
REQ-014 SHALL, on a write (enable=1, wr=1), store data_in at the indexed word at the end of that cycle and SHALL produce no data_valid.
REQ-015 SHALL, on a read (enable=1, wr=0) in cycle N, capture the indexed word as it stands at the start of cycle N.
REQ-016 SHALL return a read captured in cycle N on data_out with data_valid=1 in cycle N+LATENCY.
REQ-017 SHALL be fully pipelined: back-to-back reads on consecutive cycles return on consecutive cycles, in order, with up to LATENCY reads in flight.
REQ-018 SHALL NOT let a write issued after a read has been captured alter that read's returned data, including a write to the same word.
REQ-019 SHALL let a read in any cycle after a write to the same word return the written value.
REQ-020 SHALL drive data_out = 16'h0000 whenever data_valid = 0.
REQ-021 SHALL update pending as follows: +1 on a read accept, -1 on a return, unchanged when both occur in the same cycle; its maximum value is LATENCY.
REQ-022 SHALL treat enable=0 cycles as bubbles that produce no data_valid LATENCY cycles later.
REQ-023 SHALL ignore wr, addr and data_in when enable = 0.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set data_valid=0, data_out=16'h0000 and pending=0, and clear every in-flight pipeline stage.
REQ-025 SHALL discard reads in flight when rst asserts mid-operation; no data_valid is produced for them after reset deasserts.
REQ-026 SHALL leave storage contents unchanged by reset.
REQ-027 SHALL ignore requests presented in a cycle where rst=1; no write occurs and no read is accepted.
REQ-028 SHALL accept a request in the first cycle after rst deasserts.

Verification
REQ-029 Write sweep then line fill: write words 16'hA000..16'hA007 to addr 16'h1230..16'h123E, then issue 8 back-to-back reads of 16'h1230..16'h123E. Required response: data_valid high on 8 consecutive cycles starting exactly 4 cycles after the first read, with data 16'hA000..16'hA007 in order, and pending peaking at 4.
REQ-030 Write hazard: read 16'h0040 (holding 16'h1111) in cycle N, then write 16'h2222 to 16'h0040 in cycle N+1. Required response: the cycle N+4 return is 16'h1111, and a read of 16'h0040 issued in cycle N+2 returns 16'h2222.
REQ-031 Bubbles: issue reads in cycles 0, 2 and 3 only. Required response: data_valid=1 in cycles 4, 6 and 7, data_valid=0 in cycle 5 with data_out=0, and pending=0 after cycle 7.
REQ-032 Reset mid-fill: issue 3 reads, then assert rst for 1 cycle before any read returns. Required response: no data_valid afterwards, pending=0, and previously written contents still readable.
REQ-033 Aliasing and byte bit: write 16'hBEEF to 16'h0003, then read 16'h0002 and, with DEPTH_LOG2=10, read 16'h0802. Required response: both reads return 16'hBEEF.
REQ-034 Latency parameter: instantiate with LATENCY=1 and repeat the REQ-029 stimulus. Required response: each read returns in the very next cycle, and pending never exceeds 1.
